// File: rtl/conv_enc_k3.sv
// -----------------------------------------------------------------------------
// conv_enc_k3 - rate-1/2, constraint-length-3 convolutional encoder.
//
// Takes a serial information bit stream in frames of FRAME_LEN bits and emits
// one 2-bit code symbol per encoded bit through a single registered output
// stage. Both sides use valid/ready handshakes.
//
// Build option (macro TAIL_FLUSH_EN):
//   defined     - zero-tail termination: two extra symbols per frame encode
//                 b=0 so the trellis ends in state 0; out_last marks the
//                 second tail symbol.
//   not defined - truncated mode: no tail; out_last marks the symbol of the
//                 final information bit and the state is cleared on that edge.
//
// Parameters:
//   FRAME_LEN  information bits per frame (2..1023)
//   G0         generator for out_sym[1] (bit 2: new bit, bit 1: s[1], bit 0: s[0])
//   G1         generator for out_sym[0] (same tap order)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   in_bit     information bit
//   in_valid   in_bit is valid
//   in_ready   encoder accepts in_bit this cycle (0 while reset is high)
//   out_sym    code symbol {c0,c1}
//   out_valid  out_sym is valid
//   out_ready  downstream accepts out_sym this cycle
//   out_last   out_sym is the final symbol of the frame
//   busy       frame in progress or output stage occupied
// -----------------------------------------------------------------------------
module conv_enc_k3 #(
  parameter int           FRAME_LEN = 16,
  parameter logic [2:0]   G0        = 3'b111,
  parameter logic [2:0]   G1        = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] out_sym,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

`ifdef TAIL_FLUSH_EN
  typedef enum logic {ST_DATA, ST_TAIL} state_t;
  state_t state, state_nxt;
  logic   tail_idx, tail_nxt;
`endif

  // s[1] is the most recent encoded bit, s[0] the one before it.
  logic [1:0]    s, s_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic       free;
  logic       ready_int;
  logic       load;
  logic       enc_b;
  logic       last_nxt;
  logic [2:0] w;
  logic [1:0] sym_nxt;

  // ---------------------------------------------------------------------------
  // Next-state / output-stage load decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    free      = !out_valid || out_ready;
    ready_int = 1'b0;
    load      = 1'b0;
    enc_b     = 1'b0;
    last_nxt  = 1'b0;
    s_nxt     = s;
    cnt_nxt   = cnt;
`ifdef TAIL_FLUSH_EN
    state_nxt = state;
    tail_nxt  = tail_idx;

    if (state == ST_TAIL) begin
      // Flush two zeros through the register; in_valid is ignored here.
      if (free) begin
        load  = 1'b1;
        enc_b = 1'b0;
        if (tail_idx) begin
          last_nxt  = 1'b1;
          s_nxt     = 2'b00;
          state_nxt = ST_DATA;
        end else begin
          tail_nxt = 1'b1;
          s_nxt    = {1'b0, s[1]};
        end
      end
    end else
`endif
    begin
      ready_int = free;
      if (in_valid && free) begin
        load  = 1'b1;
        enc_b = in_bit;
        s_nxt = {in_bit, s[1]};
        if (cnt == LAST_IDX) begin
          cnt_nxt = '0;
`ifdef TAIL_FLUSH_EN
          state_nxt = ST_TAIL;
          tail_nxt  = 1'b0;
`else
          // Truncated frame: this symbol closes it and the next frame starts
          // from state 0.
          last_nxt = 1'b1;
          s_nxt    = 2'b00;
`endif
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end

    w       = {enc_b, s};
    sym_nxt = {^(w & G0), ^(w & G1)};
  end

  assign in_ready = ready_int && !reset;

`ifdef TAIL_FLUSH_EN
  assign busy = (state == ST_TAIL) || (cnt != '0) || out_valid;
`else
  assign busy = (cnt != '0) || out_valid;
`endif

  // ---------------------------------------------------------------------------
  // State and output register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      s         <= 2'b00;
      cnt       <= '0;
      out_sym   <= 2'b00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef TAIL_FLUSH_EN
      state     <= ST_DATA;
      tail_idx  <= 1'b0;
`endif
    end else begin
      s   <= s_nxt;
      cnt <= cnt_nxt;
`ifdef TAIL_FLUSH_EN
      state    <= state_nxt;
      tail_idx <= tail_nxt;
`endif
      if (load) begin
        // A load in the same cycle as out_ready replaces the held symbol.
        out_sym   <= sym_nxt;
        out_valid <= 1'b1;
        out_last  <= last_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_enc_k3.sv
// -----------------------------------------------------------------------------
// tb_conv_enc_k3 - directed self-checking bench for conv_enc_k3, FRAME_LEN=4.
// Expected symbol tables are hand-computed for both build options.
// Captured entries are {out_sym, out_last}.
// -----------------------------------------------------------------------------
module tb_conv_enc_k3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_sym;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [2:0] cap_q[$];
  logic [2:0] e[0:11];

`ifdef TAIL_FLUSH_EN
  localparam int         FS      = 6;
  localparam int         T3_CYC  = 10;
  localparam logic [19:0] T3_RDY = 20'hFFFCF;
`else
  localparam int         FS      = 4;
  localparam int         T3_CYC  = 8;
  localparam logic [19:0] T3_RDY = 20'hFFFFF;
`endif

  conv_enc_k3 #(.FRAME_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sym   (out_sym),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Record each handshake one half-cycle before the edge that completes it.
  always @(negedge clk)
    if (!reset && out_valid && out_ready) cap_q.push_back({out_sym, out_last});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_1011();
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
  endtask

  task automatic wait_count(input int n);
    for (int i = 0; i < 60 && cap_q.size() < n; i++) tick();
  endtask

  task automatic check_seq(input string tag, input int n);
    check({tag, "_count"}, cap_q.size(), n);
    for (int i = 0; i < n && i < cap_q.size(); i++)
      check($sformatf("%s_sym%0d", tag, i), cap_q[i], e[i]);
  endtask

  task automatic load_1011();
`ifdef TAIL_FLUSH_EN
    e = '{3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b111,
          3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
`else
    e = '{3'b110, 3'b100, 3'b000, 3'b011, 3'b000, 3'b000,
          3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
`endif
  endtask

  initial begin
    int acc;
    int c;

    reset     = 1'b1;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // ---- reset state ----
    tick(); tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    tick();

    // ---- 1: basic frame 1,0,1,1 ----
    cap_q.delete();
    load_1011();
    send_bit(1);
    check("t1_first_valid", out_valid, 1);
    check("t1_first_sym", out_sym, 2'b11);
    check("t1_busy_mid", busy, 1);
    send_bit(0); send_bit(1); send_bit(1);
    wait_count(FS);
    check("t1_busy_low", busy, 0);
    check("t1_valid_low", out_valid, 0);
    tick(); tick();
    check_seq("t1", FS);

    // ---- 2: output stall after the second symbol ----
    cap_q.delete();
    send_bit(1); send_bit(0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t2_stall_ready%0d", i), in_ready, 0);
      check($sformatf("t2_stall_valid%0d", i), out_valid, 1);
      check($sformatf("t2_stall_sym%0d", i), out_sym, 2'b10);
      tick();
    end
    out_ready = 1'b1;
    send_bit(1); send_bit(1);
    wait_count(FS);
    tick(); tick();
    check_seq("t2", FS);

    // ---- 3: two all-zero frames back-to-back ----
    cap_q.delete();
`ifdef TAIL_FLUSH_EN
    e = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001,
          3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
`else
    e = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
          3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
`endif
    in_valid = 1'b1;
    in_bit   = 1'b0;
    acc = 0;
    c   = 0;
    while (acc < 8 && c < 20) begin
      @(negedge clk);
      check($sformatf("t3_ready_c%0d", c), in_ready, T3_RDY[c]);
      if (in_ready) acc++;
      tick();
      c++;
    end
    in_valid = 1'b0;
    check("t3_cycles", c, T3_CYC);
    wait_count(2 * FS);
    tick(); tick();
    check_seq("t3", 2 * FS);

    // ---- 4: reset after two accepted bits ----
    send_bit(1); send_bit(0);
    reset = 1'b1;
    @(negedge clk);
    check("t4_rst_ready", in_ready, 0);
    tick();
    check("t4_valid_cleared", out_valid, 0);
    check("t4_busy_cleared", busy, 0);
    reset = 1'b0;
    cap_q.delete();
    load_1011();
    send_1011();
    wait_count(FS);
    tick(); tick();
    check_seq("t4", FS);

    // ---- 5: frames 1,1,1,1 then 1,0,1,1 ----
    cap_q.delete();
`ifdef TAIL_FLUSH_EN
    e = '{3'b110, 3'b010, 3'b100, 3'b100, 3'b010, 3'b111,
          3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b111};
`else
    e = '{3'b110, 3'b010, 3'b100, 3'b101, 3'b110, 3'b100,
          3'b000, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000};
`endif
    send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    send_1011();
    wait_count(2 * FS);
    tick(); tick();
    check_seq("t5", 2 * FS);

    // ---- 6: in_valid toggling 1,0,1,0 ----
    cap_q.delete();
    load_1011();
    send_bit(1);
    check("t6_sym0", out_sym, 2'b11);
    tick();
    check("t6_gap0_valid", out_valid, 0);
    check("t6_gap0_busy", busy, 1);
    send_bit(0);
    check("t6_sym1", out_sym, 2'b10);
    tick();
    check("t6_gap1_valid", out_valid, 0);
    send_bit(1);
    check("t6_sym2", out_sym, 2'b00);
    tick();
    check("t6_gap2_valid", out_valid, 0);
    check("t6_gap2_busy", busy, 1);
    send_bit(1);
    check("t6_sym3", out_sym, 2'b01);
    wait_count(FS);
    tick(); tick();
    check_seq("t6", FS);
    check("t6_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_enc_k3.md
Name: conv_enc_k3

Overview:
Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the 4-state Viterbi decoder (BMU/ACS/path-metric memory/traceback).
- Accepts a serial information bit stream in fixed-length frames.
- Emits one 2-bit code symbol per bit.
- Appends a zero tail so every frame ends in trellis state 0, which is the state the decoder's traceback starts from.
- Valid/ready handshakes on both sides, with a single registered output stage.

Parameters:
FRAME_LEN, 16, information bits per frame; legal range 2..1023.
G0, 3'b111, generator polynomial for symbol bit 1 (octal 7); bit 2 taps the new bit, bit 1 taps s[1], bit 0 taps s[0].
G1, 3'b101, generator polynomial for symbol bit 0 (octal 5); same tap order.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
in_bit  input  1  information bit
in_valid  input  1  in_bit is valid
in_ready  output  1  encoder can accept in_bit this cycle
out_sym  output  2  code symbol {c0,c1}; c0 from G0 on bit 1, c1 from G1 on bit 0
out_valid  output  1  out_sym is valid
out_ready  input  1  downstream accepts out_sym this cycle
out_last  output  1  qualifies out_sym as final symbol of the frame
busy  output  1  frame in progress or output stage occupied

Behaviour:
- Reset (reset high at a clk edge):
  - s[1:0]=0, bit counter=0, FSM=DATA.
  - out_valid=0, out_sym=2'b00, out_last=0.
  - in_ready is forced 0 while reset is high.
  - Reset mid-frame discards the partial frame and any pending output symbol; no tail is emitted.
- Encoder state: s[1] is the most recent bit, s[0] the older one.
  - Word w={b,s[1],s[0]}.
  - c0 = XOR-reduce(w & G0); c1 = XOR-reduce(w & G1).
  - After each encoded bit: s <= {b,s[1]}.
- Output stage is free when !out_valid || out_ready.
- FSM state DATA:
  - in_ready = free (combinational).
  - Accept when in_valid && in_ready: b=in_bit; out_sym, out_valid=1 and out_last=0 register on that edge (latency 1 cycle); counter increments.
  - On acceptance of bit number FRAME_LEN: counter clears and FSM goes to TAIL with tail index 0.
- FSM state TAIL:
  - in_ready=0.
  - Each cycle the output stage is free, encode b=0 and load out_sym with out_valid=1.
  - First tail symbol: out_last=0.
  - Second tail symbol: out_last=1; s becomes 00; FSM returns to DATA.
- Output stage holding:
  - If out_valid && !out_ready, out_sym and out_last hold stable and no state advances.
  - If out_ready && no new symbol is loaded that cycle, out_valid <= 0 (and out_last <= 0).
- Throughput: with out_ready held high, one symbol per cycle, including back-to-back frames with no bubble other than the 2 tail cycles.
- Simultaneous events: out_ready and a new load in the same cycle replace the register contents (no bubble). in_valid while in TAIL is ignored; the bit is not consumed.
- busy = (FSM==TAIL) || (counter!=0) || out_valid.
- Symbols per frame: 2*(FRAME_LEN+2) code bits.

Optional Feature:
Macro TAIL_FLUSH_EN.
- Defined: zero-tail termination as above.
- Not defined: truncated mode.
  - TAIL state is not built.
  - The symbol for information bit FRAME_LEN carries out_last=1.
  - s is cleared to 00 on that same edge; FSM stays in DATA.
  - Frame length in symbols is FRAME_LEN.

Test Plan:
1. FRAME_LEN=4, TAIL_FLUSH_EN, out_ready=1, bits 1,0,1,1 -> out_sym 11,10,00,01, then tail 01,11 with out_last only on the final 11; busy low 1 cycle after the final symbol handshake.
2. Same frame with out_ready low for 3 cycles after the second symbol -> out_sym=10 held stable, in_ready=0 throughout the stall, sequence unchanged, no duplicate or dropped symbol.
3. Two frames back-to-back, FRAME_LEN=4, all-zero data -> 12 symbols all 00; out_last on symbols 6 and 12; in_ready low exactly during the 2 tail cycles of each frame.
4. Reset asserted after 2 accepted bits of a frame -> next cycle out_valid=0 and busy=0; a new frame 1,0,1,1 produces 11,10,00,01,01,11 (state and counter start from 0).
5. Without TAIL_FLUSH_EN, FRAME_LEN=4, bits 1,1,1,1 then 1,0,1,1 -> 11,01,10,10 (out_last on 4th), then 11,10,00,01 (out_last on 4th).
6. in_valid toggling 1,0,1,0 with out_ready=1 -> symbols emitted only on accepted bits; the counter counts accepted bits only, and out_last aligns with the FRAME_LEN-th accepted bit plus tail.
